// File: rtl/systolic_drain_if.sv
// Handshake bundle between a systolic array's bottom row and the drain block:
// skewed partial sums in, de-skewed result rows out with valid/ready flow control.
interface systolic_drain_if #(
  parameter int N     = 4,
  parameter int ACC_W = 8
);
  logic               clear;
  logic               in_start;
  logic [N*ACC_W-1:0] psum_in;
  logic [N*ACC_W-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               overflow;

  modport master (
    output clear, in_start, psum_in, out_ready,
    input  out_data, out_valid, busy, done, overflow
  );

  modport slave (
    input  clear, in_start, psum_in, out_ready,
    output out_data, out_valid, busy, done, overflow
  );
endinterface

// File: rtl/systolic_drain.sv
// Drains a systolic array: de-skews the bottom-row partial sums so each result row
// is column-aligned, then buffers the rows in a small FIFO for a valid/ready consumer.
module systolic_drain #(
  parameter int N     = 4,
  parameter int ACC_W = 8,
  parameter int ROWS  = 4,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  systolic_drain_if.slave  bus
);
  localparam int W         = N * ACC_W;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(ROWS + 1);
  localparam int WAIT_W    = $clog2(N + 1);
  localparam int WAIT_INIT = (N > 1) ? (N - 2) : 0;
  localparam bit ZERO_SKEW = (N == 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_row;
  logic [WAIT_W-1:0] r_wait;
  logic              r_busy;
  logic              r_done;

  logic [W-1:0]      w_aligned;
  logic [W-1:0]      r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W-1:0]  w_rptr_next;
  logic [PTR_W:0]    r_count;
  logic [PTR_W:0]    w_count_next;
  logic              r_valid;
  logic              r_overflow;
  logic [W-1:0]      r_out_data;
  logic [W-1:0]      w_head_next;
  logic              w_push_req;
  logic              w_push_eff;
  logic              w_pop;
  logic              w_full;
  logic              w_last_row;

  // Column j sees row r j cycles late; delaying it N-1-j stages lines every column up.
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j == N - 1) begin : g_direct
      assign w_aligned[j*ACC_W +: ACC_W] = bus.psum_in[j*ACC_W +: ACC_W];
    end else begin : g_delay
      localparam int STG = N - 1 - j;
      logic [ACC_W-1:0] r_sr [STG];

      // Per-column deskew shift register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < STG; k++) r_sr[k] <= '0;
        end else if (bus.clear) begin
          for (int k = 0; k < STG; k++) r_sr[k] <= '0;
        end else begin
          r_sr[0] <= bus.psum_in[j*ACC_W +: ACC_W];
          for (int k = 1; k < STG; k++) r_sr[k] <= r_sr[k-1];
        end
      end

      assign w_aligned[j*ACC_W +: ACC_W] = r_sr[STG-1];
    end
  end

  // Push/pop decisions and the next FIFO head, computed ahead so out_data is a register.
  always_comb begin
    w_pop      = r_valid & bus.out_ready & ~bus.clear;
    w_full     = (r_count == (PTR_W+1)'(DEPTH));
    w_last_row = (r_row == CNT_W'(ROWS - 1));
    if (bus.clear) begin
      w_push_req = 1'b0;
    end else if ((r_state == CAPTURE) && (r_wait == '0)) begin
      w_push_req = 1'b1;
    end else if (ZERO_SKEW && (r_state == IDLE) && bus.in_start) begin
      w_push_req = 1'b1;
    end else begin
      w_push_req = 1'b0;
    end
    w_push_eff   = w_push_req & (~w_full | w_pop);
    w_rptr_next  = w_pop ? (r_rptr + PTR_W'(1)) : r_rptr;
    w_count_next = r_count + (PTR_W+1)'(w_push_eff) - (PTR_W+1)'(w_pop);
    // The incoming row becomes the head only when it lands where the read pointer will be.
    if (w_push_eff && (r_wptr == w_rptr_next)) begin
      w_head_next = w_aligned;
    end else begin
      w_head_next = r_mem[w_rptr_next];
    end
  end

  // Job sequencing: wait for row 0 to align, push ROWS rows, then wait for the FIFO to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_wait  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.clear) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_wait  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_start) begin
            r_wait <= WAIT_W'(WAIT_INIT);
            r_busy <= 1'b1;
            // With no skew, row 0 is already aligned and pushed in the start cycle.
            r_row  <= ZERO_SKEW ? CNT_W'(1) : CNT_W'(0);
            if (ZERO_SKEW && (ROWS == 1)) begin
              r_state <= DRAIN;
            end else begin
              r_state <= CAPTURE;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        CAPTURE: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - WAIT_W'(1);
          end else begin
            r_row <= r_row + CNT_W'(1);
            if (w_last_row) begin
              r_state <= DRAIN;
            end else begin
              r_state <= CAPTURE;
            end
          end
        end
        DRAIN: begin
          if (w_count_next == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_row   <= '0;
          end else begin
            r_state <= DRAIN;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_row   <= '0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_out_data <= '0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_out_data <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_eff) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      r_rptr     <= w_rptr_next;
      r_count    <= w_count_next;
      r_valid    <= (w_count_next != '0);
      r_out_data <= w_head_next;
      if (w_push_req && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  // Row storage; occupancy and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_eff) begin
      r_mem[r_wptr] <= w_aligned;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: a DEPTH=4 instance for the main scenarios and a
// DEPTH=2 instance, never read by default, for row dropping and the sticky overflow flag.
module tb_systolic_drain;
  localparam int N     = 4;
  localparam int ACC_W = 8;
  localparam int ROWS  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cmps  = 0;
  int   errs  = 0;
  int   cyc   = 0;
  int   job_t = -1000;
  logic [31:0] rowv [4];

  always #5 clk = ~clk;

  systolic_drain_if #(.N(N), .ACC_W(ACC_W)) ifa ();
  systolic_drain_if #(.N(N), .ACC_W(ACC_W)) ifb ();

  systolic_drain #(.N(N), .ACC_W(ACC_W), .ROWS(ROWS), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  systolic_drain #(.N(N), .ACC_W(ACC_W), .ROWS(ROWS), .DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  // Column j carries row r (value 0x10*r+j) at cycle t+r+j; anything else is filler 0xEE.
  function automatic logic [31:0] skew_word(int c, int t);
    logic [31:0] w;
    int r;
    for (int j = 0; j < N; j++) begin
      r = c - t - j;
      if (r >= 0 && r < ROWS) w[j*8 +: 8] = 8'(16 * r + j);
      else                    w[j*8 +: 8] = 8'hEE;
    end
    return w;
  endfunction

  task automatic drive();
    ifa.psum_in = skew_word(cyc, job_t);
    ifb.psum_in = skew_word(cyc, job_t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ifa.in_start = 1'b0;
    ifb.in_start = 1'b0;
    ifa.clear    = 1'b0;
    ifb.clear    = 1'b0;
    drive();
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_job();
    tick();
    job_t = cyc;
    drive();
    ifa.in_start = 1'b1;
    ifb.in_start = 1'b1;
  endtask

  // One job on dut_a with out_ready=1; restart>0 re-pulses in_start at T+restart.
  task automatic run_job(string tag, int restart);
    start_job();
    chk($sformatf("%s.busy@0", tag), ifa.busy, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == restart) begin
        ifa.in_start = 1'b1;
        ifb.in_start = 1'b1;
      end
      if (k >= 4 && k <= 7) begin
        chk($sformatf("%s.valid@%0d", tag, k), ifa.out_valid, 1'b1);
        chk($sformatf("%s.data@%0d", tag, k), ifa.out_data, rowv[k-4]);
      end else begin
        chk($sformatf("%s.valid@%0d", tag, k), ifa.out_valid, 1'b0);
      end
      chk($sformatf("%s.done@%0d", tag, k), ifa.done, (k == 8));
      chk($sformatf("%s.busy@%0d", tag, k), ifa.busy, (k <= 7));
    end
  endtask

  initial begin
    rowv[0] = 32'h0302_0100;
    rowv[1] = 32'h1312_1110;
    rowv[2] = 32'h2322_2120;
    rowv[3] = 32'h3332_3130;
    rst_n = 1'b0;
    ifa.clear = 1'b0; ifb.clear = 1'b0;
    ifa.in_start = 1'b0; ifb.in_start = 1'b0;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b0;
    drive();
    repeat (3) tick();
    chk("rst.valid", ifa.out_valid, 1'b0);
    chk("rst.data", ifa.out_data, 32'h0);
    chk("rst.busy", ifa.busy, 1'b0);
    chk("rst.done", ifa.done, 1'b0);
    chk("rst.ovf", ifa.overflow, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_job("basic", -1);
    repeat (2) tick();
    run_job("restart", 2);
    repeat (2) tick();

    // Backpressure: consumer stalls until T+12, then drains one row per cycle.
    ifa.out_ready = 1'b0;
    start_job();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 12) ifa.out_ready = 1'b1;
      if (k >= 4 && k <= 15) begin
        chk($sformatf("bp.valid@%0d", k), ifa.out_valid, 1'b1);
        chk($sformatf("bp.data@%0d", k), ifa.out_data, (k < 12) ? rowv[0] : rowv[k-12]);
      end else begin
        chk($sformatf("bp.valid@%0d", k), ifa.out_valid, 1'b0);
      end
      chk($sformatf("bp.done@%0d", k), ifa.done, (k == 16));
    end
    chk("bp.ovf", ifa.overflow, 1'b0);
    chk("bp.busy_end", ifa.busy, 1'b0);
    repeat (2) tick();

    // Abort with reset at T+5; outputs drop without waiting for a clock edge.
    start_job();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("abort.valid", ifa.out_valid, 1'b0);
    chk("abort.busy", ifa.busy, 1'b0);
    chk("abort.data", ifa.out_data, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    run_job("after_rst", -1);
    repeat (2) tick();

    // Clear together with in_start at T+6: clear wins, no done pulse, no new job.
    start_job();
    repeat (6) tick();
    ifa.clear = 1'b1; ifb.clear = 1'b1;
    ifa.in_start = 1'b1; ifb.in_start = 1'b1;
    for (int k = 7; k <= 8; k++) begin
      tick();
      chk($sformatf("clr.busy@%0d", k), ifa.busy, 1'b0);
      chk($sformatf("clr.valid@%0d", k), ifa.out_valid, 1'b0);
      chk($sformatf("clr.done@%0d", k), ifa.done, 1'b0);
      chk($sformatf("clr.b_busy@%0d", k), ifb.busy, 1'b0);
    end
    tick();

    // Clean job after clear; dut_b never read, so rows 2 and 3 overflow its 2-deep FIFO.
    run_job("clean", -1);
    chk("ovf.a_flag", ifa.overflow, 1'b0);
    chk("ovf.b_flag", ifb.overflow, 1'b1);
    chk("ovf.b_valid", ifb.out_valid, 1'b1);
    chk("ovf.b_data0", ifb.out_data, rowv[0]);
    chk("ovf.b_busy", ifb.busy, 1'b1);
    ifb.out_ready = 1'b1;
    tick();
    chk("ovf.b_data1", ifb.out_data, rowv[1]);
    chk("ovf.b_valid1", ifb.out_valid, 1'b1);
    ifb.out_ready = 1'b1;
    tick();
    chk("ovf.b_empty", ifb.out_valid, 1'b0);
    chk("ovf.b_done", ifb.done, 1'b1);
    chk("ovf.b_sticky", ifb.overflow, 1'b1);
    ifb.out_ready = 1'b0;
    tick();
    chk("ovf.b_sticky2", ifb.overflow, 1'b1);
    ifa.clear = 1'b1; ifb.clear = 1'b1;
    tick();
    chk("ovf.b_cleared", ifb.overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 Parameter N, default 4, number of array columns drained.
REQ-002 Parameter ACC_W, default 8, partial-sum width per column.
REQ-003 Parameter ROWS, default 4, result rows per job (ROWS >= 1).
REQ-004 Parameter DEPTH, default 4, output FIFO depth in rows (power of two, >= 2).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 clear  input  1  synchronous abort, active-high.
REQ-008 in_start  input  1  one-cycle pulse, column 0 row 0 present on psum_in this cycle.
REQ-009 psum_in  input  N*ACC_W  bottom-row psum_out of all columns; column j at bits [j*ACC_W +: ACC_W].
REQ-010 out_data  output  N*ACC_W  de-skewed result row, same column packing.
REQ-011 out_valid  output  1  out_data holds an unread row.
REQ-012 out_ready  input  1  consumer accepts row when out_valid && out_ready.
REQ-013 busy  output  1  high in CAPTURE or DRAIN.
REQ-014 done  output  1  one-cycle pulse at job completion.
REQ-015 overflow  output  1  sticky: a row was dropped because the FIFO was full.

Function
REQ-016 Skew contract: after in_start at cycle T, column j row r is valid on psum_in at cycle T+r+j, for r in 0..ROWS-1.
REQ-017 Column j is delayed by N-1-j register stages, so all columns of row r are aligned at cycle T+r+N-1; column N-1 gets no delay.
REQ-018 Data passes bit-exact; no arithmetic, no sign handling, no width change.
REQ-019 FSM states: IDLE, CAPTURE, DRAIN.
REQ-020 IDLE -> CAPTURE on in_start; aligned-row counter loads 0.
REQ-021 In CAPTURE, at the edge ending cycle T+r+N-1, row r is pushed into the FIFO and the counter increments; push count is exactly ROWS.
REQ-022 CAPTURE -> DRAIN on the edge that pushes row ROWS-1.
REQ-023 DRAIN -> IDLE when the FIFO is empty (including same-cycle pop of the last row); done pulses for exactly one cycle in the first IDLE cycle.
REQ-024 in_start while busy is ignored; it does not restart or corrupt the job.
REQ-025 FIFO is registered; row r is visible on out_data with out_valid=1 no earlier than cycle T+r+N (first-row latency N cycles from in_start).
REQ-026 out_valid=1 iff FIFO non-empty; out_data is the oldest row and is stable while out_valid && !out_ready.
REQ-027 Push and pop in the same cycle are both performed; occupancy unchanged; legal when full only if a pop occurs.
REQ-028 Push while full without same-cycle pop: the row is dropped, overflow is set, and the counter still increments.
REQ-029 FIFO pointers wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.
REQ-030 busy=1 in CAPTURE and DRAIN, 0 in IDLE.
REQ-031 clear: FIFO is emptied, deskew registers are zeroed, FSM goes to IDLE, counter goes to 0, overflow goes to 0, and no done pulse occurs; clear wins over in_start in the same cycle.

Reset
REQ-032 While rst=0, all registers are asynchronously forced: FSM=IDLE, deskew registers=0, FIFO empty, pointers=0, counter=0.
REQ-033 Output reset values: out_valid=0, out_data=0, busy=0, done=0, overflow=0.
REQ-034 Reset asserted mid-job abandons the job; after release the block is in IDLE and accepts a new in_start.

Verification (N=4, ROWS=4, DEPTH=4, ACC_W=8)
REQ-035 Basic drain: in_start at T; column j row r = 0x10*r+j per REQ-016 skew; out_ready=1 -> rows {00,01,02,03}..{30,31,32,33} appear at T+4..T+7; done pulses at T+8.
REQ-036 Backpressure: same stimulus with out_ready=0 until T+12 -> all 4 rows held in order, no overflow; done pulses one cycle after the 4th pop.
REQ-037 Overflow: DEPTH=2, out_ready=0 -> only rows 0 and 1 are retained, overflow=1 and stays 1 until clear or reset.
REQ-038 Ignored restart: second in_start at T+2 -> output is identical to REQ-035.
REQ-039 Abort: rst=0 at T+5 -> out_valid=0, busy=0 immediately; a new job after release completes exactly as in REQ-035.
REQ-040 Clear with simultaneous in_start at T+6 -> state IDLE, FIFO empty, no done pulse; the next in_start starts a clean job.
